// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared constants and helpers for the RV32M multiply/divide unit.
//   - M-extension opcode / funct7 / funct3 codes (INST_MUL .. INST_REMU)
//   - FSM state encoding
//   - conditional two's-complement negation helpers
package ex_muldiv_pkg;

  localparam logic [6:0] INST_OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] INST_FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  // Negate a 32-bit value when neg is set.
  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  // Negate a 64-bit value when neg is set.
  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/gen_dff_set.sv
// gen_dff_set: parametrised D flip-flop whose synchronous reset loads SET_VAL.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (loads SET_VAL)
//   d_i  : next value
//   q_o  : registered value
module gen_dff_set #(
  parameter int            DW      = 32,
  parameter logic [DW-1:0] SET_VAL = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] q_q;

  // storage register with synchronous set
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= SET_VAL;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/muldiv_iter.sv
// muldiv_iter: radix-2 iterative datapath shared by multiply and divide.
//   clk, rst     : clock, synchronous active-high reset
//   load_i       : load magnitudes (acc = {0, a_i}, operand = b_i)
//   step_i       : perform one iteration
//   is_div_i     : 1 = restoring divide step, 0 = shift-add multiply step
//   a_i, b_i     : operand magnitudes (multiplier/dividend, multiplicand/divisor)
//   acc_next_o   : accumulator value after the current step (combinational)
// Multiply: acc = {partial_hi, multiplier}; after XLEN steps acc = product.
// Divide:   acc = {remainder, dividend/quotient}; after XLEN steps
//           acc[2*XLEN-1:XLEN] = remainder and acc[XLEN-1:0] = quotient.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_next_o
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] step_val;

  // one iteration of either algorithm, plus load/step selection
  always_comb begin
    add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    // 33-bit partial remainder: old remainder shifted left with next dividend bit
    shifted  = acc_q[2*XLEN-1:XLEN-1];
    diff     = shifted - {1'b0, b_q};
    step_val = acc_q;
    if (is_div_i) begin
      if (!diff[XLEN]) begin
        step_val = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        step_val = {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end else begin
      step_val = {add_sum, acc_q[XLEN-1:1]};
    end

    acc_d = acc_q;
    b_d   = b_q;
    if (load_i) begin
      acc_d = {{XLEN{1'b0}}, a_i};
      b_d   = b_i;
    end else if (step_i) begin
      acc_d = step_val;
    end else begin
      acc_d = acc_q;
    end
  end

  // accumulator and operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= {(2*XLEN){1'b0}};
      b_q   <= {XLEN{1'b0}};
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
    end
  end

  assign acc_next_o = step_val;

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit on the execute side of ID/EX.
//   clk, rst         : clock, synchronous active-high reset
//   start_i          : M-extension request present in EX
//   funct3_i         : operation select (MUL..REMU)
//   op1_i, op2_i     : rs1 / rs2 values
//   rd_addr_i        : destination register
//   flush_i          : abort current operation, return to IDLE
//   hold_o           : stall request to IF/ID and ID/EX
//   busy_o           : operation in flight
//   valid_o          : one-cycle result pulse
//   result_o         : result (registered, 0 outside DONE)
//   rd_addr_o        : destination of result (registered, 0 outside DONE)
//   reg_wen_o        : register write enable, same as valid_o
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            hold_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_wen_o
);

  muldiv_state_e state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [4:0]    rd_q, rd_d;
  logic          neg_q, neg_d;

  logic          accept;
  logic          is_div;
  logic          sign1, sign2;
  logic [31:0]   mag1, mag2;
  logic          neg_cap;
  logic          div_zero, div_ovf;
  logic [31:0]   special_res;
  logic [63:0]   acc_next;
  logic [63:0]   prod;
  logic [31:0]   calc_res;
  logic [31:0]   res_d;
  logic [4:0]    rdo_d;
  logic          valid_d;
  logic          valid_q;

  assign accept = (state_q == ST_IDLE) && start_i && !flush_i;
  assign is_div = funct3_i[2];

  // operand signedness, magnitudes, result sign and special divide cases
  always_comb begin
    // divides: DIV/REM signed; multiplies: op1 signed unless MULHU, op2 signed for MUL/MULH
    if (is_div) begin
      sign1 = !funct3_i[0] && op1_i[31];
      sign2 = !funct3_i[0] && op2_i[31];
    end else begin
      sign1 = (funct3_i != INST_MULHU) && op1_i[31];
      sign2 = !funct3_i[1] && op2_i[31];
    end
    mag1 = cond_neg32(op1_i, sign1);
    mag2 = cond_neg32(op2_i, sign2);
    // remainder takes the dividend's sign; product/quotient take the xor
    if (is_div && funct3_i[1]) begin
      neg_cap = sign1;
    end else begin
      neg_cap = sign1 ^ sign2;
    end
    div_zero = is_div && (op2_i == 32'h0000_0000);
    div_ovf  = is_div && !funct3_i[0] && (op1_i == 32'h8000_0000) && (op2_i == 32'hFFFF_FFFF);
    if (div_zero) begin
      special_res = funct3_i[1] ? op1_i : 32'hFFFF_FFFF;
    end else begin
      special_res = funct3_i[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .step_i     (state_q == ST_CALC),
    .is_div_i   (funct3_q[2]),
    .a_i        (mag1),
    .b_i        (mag2),
    .acc_next_o (acc_next)
  );

  // final result from the last iteration's accumulator, sign-corrected
  always_comb begin
    prod = cond_neg64(acc_next, neg_q);
    if (funct3_q[2]) begin
      if (funct3_q[1]) begin
        calc_res = cond_neg32(acc_next[63:32], neg_q);
      end else begin
        calc_res = cond_neg32(acc_next[31:0], neg_q);
      end
    end else if (funct3_q == INST_MUL) begin
      calc_res = prod[31:0];
    end else begin
      calc_res = prod[63:32];
    end
  end

  // next-state logic, operand capture and output register inputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    res_d    = 32'h0000_0000;
    rdo_d    = 5'd0;
    valid_d  = 1'b0;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            funct3_d = funct3_i;
            rd_d     = rd_addr_i;
            neg_d    = neg_cap;
            cnt_d    = 5'd0;
            if (div_zero || div_ovf) begin
              state_d = ST_DONE;
              res_d   = special_res;
              rdo_d   = rd_addr_i;
              valid_d = 1'b1;
            end else begin
              state_d = ST_CALC;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CALC: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(ITER - 1)) begin
            state_d = ST_DONE;
            res_d   = calc_res;
            rdo_d   = rd_q;
            valid_d = 1'b1;
          end else begin
            state_d = ST_CALC;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM and captured-operation registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      funct3_q <= 3'b000;
      rd_q     <= 5'd0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
    end
  end

  gen_dff_set #(.DW(32), .SET_VAL(32'h0000_0000)) u_res_dff (
    .clk (clk), .rst (rst), .d_i (res_d), .q_o (result_o)
  );

  gen_dff_set #(.DW(5), .SET_VAL(5'd0)) u_rd_dff (
    .clk (clk), .rst (rst), .d_i (rdo_d), .q_o (rd_addr_o)
  );

  gen_dff_set #(.DW(1), .SET_VAL(1'b0)) u_valid_dff (
    .clk (clk), .rst (rst), .d_i (valid_d), .q_o (valid_q)
  );

  // a flush arriving while DONE is shown kills the write-back
  assign valid_o   = valid_q && !flush_i;
  assign reg_wen_o = valid_q && !flush_i;
  assign hold_o    = accept || (state_q == ST_CALC);
  assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed, table-driven bench for ex_muldiv.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        hold_o;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;
  logic        reg_wen_o;

  int total = 0;
  int bad   = 0;

  ex_muldiv dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .funct3_i  (funct3_i),
    .op1_i     (op1_i),
    .op2_i     (op2_i),
    .rd_addr_i (rd_addr_i),
    .flush_i   (flush_i),
    .hold_o    (hold_o),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .result_o  (result_o),
    .rd_addr_o (rd_addr_o),
    .reg_wen_o (reg_wen_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int lat,
                         input string name);
    vec_t v;
    v.f3 = f3; v.a = a; v.b = b; v.rd = rd; v.exp = exp; v.lat = lat; v.name = name;
    vecs.push_back(v);
  endtask

  // Called just after a negedge while the DUT is idle (that cycle is cycle 0).
  // Returns just after the negedge of the first cycle following DONE.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat,
                        input string name, input bit keep);
    int got_lat;
    int hold_bad;
    int nz_bad;
    logic [31:0] res;
    logic [4:0]  rdv;
    logic        wen;
    logic        hold_done;
    got_lat = 0; hold_bad = 0; nz_bad = 0;
    res = 32'h0; rdv = 5'd0; wen = 1'b0; hold_done = 1'b0;
    funct3_i = f3; op1_i = a; op2_i = b; rd_addr_i = rd; start_i = 1'b1;
    #1;
    check({name, " hold c0"}, {31'd0, hold_o}, 32'd1);
    @(posedge clk);
    #1;
    if (keep) begin
      funct3_i = 3'b000; op1_i = 32'h0000_1234; op2_i = 32'h0000_0005; rd_addr_i = 5'd31;
    end else begin
      start_i = 1'b0;
    end
    for (int n = 1; n <= 40 && got_lat == 0; n++) begin
      @(negedge clk);
      if (valid_o) begin
        got_lat = n; res = result_o; rdv = rd_addr_o; wen = reg_wen_o; hold_done = hold_o;
      end else begin
        if (!hold_o) hold_bad++;
        if (result_o != 32'h0 || rd_addr_o != 5'd0 || reg_wen_o) nz_bad++;
      end
      if (keep && n >= 30) start_i = 1'b0;
    end
    start_i = 1'b0;
    check({name, " latency"}, got_lat, lat);
    check({name, " result"}, res, exp);
    check({name, " rd"}, {27'd0, rdv}, {27'd0, rd});
    check({name, " wen"}, {31'd0, wen}, 32'd1);
    check({name, " hold in done"}, {31'd0, hold_done}, 32'd0);
    check({name, " hold/zero while busy"}, hold_bad + nz_bad, 32'd0);
    @(negedge clk);
    check({name, " busy after"}, {31'd0, busy_o}, 32'd0);
    check({name, " outputs cleared"}, {valid_o, reg_wen_o, rd_addr_o, result_o[24:0]}, 32'd0);
  endtask

  initial begin
    int vcnt;
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
    funct3_i = 3'b000; op1_i = 32'h0; op2_i = 32'h0; rd_addr_i = 5'd0;

    add_vec(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, "MUL 7*-3");
    add_vec(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33, "MULHU max");
    add_vec(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 33, "MULH -1*-1");
    add_vec(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, 33, "MULHSU -1*2");
    add_vec(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd9,  32'h4000_0000, 33, "MULH min*min");
    add_vec(3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 33, "MUL min*-1");
    add_vec(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 32'hFFFF_FFFD, 33, "DIV -7/2");
    add_vec(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd12, 32'hFFFF_FFFF, 33, "REM -7/2");
    add_vec(3'b101, 32'd100,       32'd7,         5'd13, 32'd14,        33, "DIVU 100/7");
    add_vec(3'b111, 32'd100,       32'd7,         5'd14, 32'd2,         33, "REMU 100/7");
    add_vec(3'b100, 32'd7,         32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFD, 33, "DIV 7/-2");
    add_vec(3'b110, 32'd7,         32'hFFFF_FFFE, 5'd16, 32'h0000_0001, 33, "REM 7/-2");
    add_vec(3'b101, 32'd5,         32'd0,         5'd17, 32'hFFFF_FFFF, 1,  "DIVU 5/0");
    add_vec(3'b110, 32'd7,         32'd0,         5'd18, 32'd7,         1,  "REM 7/0");
    add_vec(3'b100, 32'hFFFF_FFFB, 32'd0,         5'd19, 32'hFFFF_FFFF, 1,  "DIV -5/0");
    add_vec(3'b111, 32'd5,         32'd0,         5'd20, 32'd5,         1,  "REMU 5/0");
    add_vec(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h8000_0000, 1,  "DIV ovf");
    add_vec(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h0000_0000, 1,  "REM ovf");

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset hold", {31'd0, hold_o}, 32'd0);
    check("reset busy", {31'd0, busy_o}, 32'd0);
    check("reset valid/wen", {30'd0, valid_o, reg_wen_o}, 32'd0);
    check("reset result", result_o, 32'd0);
    check("reset rd", {27'd0, rd_addr_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // table of directed vectors, issued back to back
    vcnt = vecs.size();
    for (int i = 0; i < vcnt; i++) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat,
             vecs[i].name, 1'b0);
    end

    // flush in cycle 10 of a MUL, then DIVU 9/3 issued at once
    funct3_i = 3'b000; op1_i = 32'd1234; op2_i = 32'd77; rd_addr_i = 5'd3; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int n = 1; n <= 9; n++) @(negedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    check("flush valid suppressed", {31'd0, valid_o}, 32'd0);
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    check("flush busy next", {31'd0, busy_o}, 32'd0);
    check("flush no valid next", {31'd0, valid_o}, 32'd0);
    run_op(3'b101, 32'd9, 32'd3, 5'd4, 32'd3, 33, "DIVU 9/3 after flush", 1'b0);

    // reset in cycle 20 of a DIV
    funct3_i = 3'b100; op1_i = 32'hFFFF_FF9C; op2_i = 32'd3; rd_addr_i = 5'd23; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int n = 1; n <= 19; n++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst mid busy", {31'd0, busy_o}, 32'd0);
    check("rst mid hold", {31'd0, hold_o}, 32'd0);
    check("rst mid valid/wen", {30'd0, valid_o, reg_wen_o}, 32'd0);
    check("rst mid result", result_o, 32'd0);
    check("rst mid rd", {27'd0, rd_addr_o}, 32'd0);
    begin
      int vseen;
      vseen = 0;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (valid_o) vseen++;
      end
      check("rst aborted no valid", vseen, 32'd0);
    end

    // start held with other operands during the busy period is ignored
    run_op(3'b100, 32'hFFFF_FF9C, 32'd7, 5'd24, 32'hFFFF_FFF2, 33, "DIV -100/7 start held", 1'b1);
    run_op(3'b110, 32'hFFFF_FF9C, 32'd7, 5'd25, 32'hFFFF_FFFE, 33, "REM -100/7", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
